// File: rtl/count_evt_pkg.sv
// Shared event-type encoding and entry-width helper for the count event packetizer.
package count_evt_pkg;

    typedef enum logic [1:0] {
        EVT_NONE   = 2'b00,
        EVT_SAMPLE = 2'b01,
        EVT_WRAP   = 2'b10,
        EVT_BOTH   = 2'b11
    } evt_type_e;

    // Packed entry layout is {type[1:0], seq[SEQ_W-1:0], count[CNT_W-1:0]}.
    function automatic int entry_width(input int cnt_w, input int seq_w);
        return 2 + seq_w + cnt_w;
    endfunction

endpackage

// File: rtl/count_event_packetizer_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head entry is visible while not empty.
module sync_fifo #(
    parameter  int WIDTH = 14,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [LW-1:0]    o_level
);

    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_full  = (r_level == FULL_LVL);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign w_wr_en = i_push && (!o_full || i_pop);
    assign w_rd_en = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_en, w_rd_en})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; pointers and level define validity,
    // and the read mux below forces zero while empty so stale contents never leak.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/count_event_packetizer.sv
// Snapshots an observed counter on sample requests or imminent wrap, tags each
// snapshot with type and sequence number, and streams it out through a FIFO.
module count_event_packetizer
    import count_evt_pkg::*;
#(
    parameter  int CNT_W   = 8,
    parameter  int DEPTH   = 4,
    parameter  int SEQ_W   = 4,
    localparam int ENTRY_W = entry_width(CNT_W, SEQ_W),
    localparam int LVL_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [CNT_W-1:0]   count_in,
    input  logic               count_en,
    input  logic               sample_req,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ENTRY_W-1:0] out_data,
    output logic               overflow,
    output logic [7:0]         drop_cnt,
    output logic [LVL_W-1:0]   level
);

    logic [SEQ_W-1:0]   r_seq;
    logic               r_overflow;
    logic [7:0]         r_drop_cnt;

    logic               w_wrap;
    logic               w_evt;
    evt_type_e          w_type;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_full;
    logic               w_empty;
    logic [ENTRY_W-1:0] w_entry;

    assign w_wrap  = count_en && (count_in == {CNT_W{1'b1}});
    assign w_evt   = w_wrap || sample_req;
    assign w_type  = evt_type_e'({w_wrap, sample_req});
    assign w_entry = {w_type, r_seq, count_in};

    assign w_pop  = out_valid && out_ready;
    assign w_push = w_evt && (!w_full || w_pop);
    assign w_drop = w_evt && w_full && !w_pop;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_wdata (w_entry),
        .i_pop   (w_pop),
        .o_rdata (out_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    assign out_valid = !w_empty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_seq      <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) r_seq <= r_seq + 1'b1;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_count_event_packetizer.sv
// Scoreboard bench: the driver queues expected entries, a negedge monitor checks each transfer.
module tb_count_event_packetizer;
    import count_evt_pkg::*;

    localparam int CNT_W   = 8;
    localparam int DEPTH   = 4;
    localparam int SEQ_W   = 4;
    localparam int ENTRY_W = 2 + SEQ_W + CNT_W;
    localparam int LVL_W   = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [CNT_W-1:0]   count_in;
    logic               count_en;
    logic               sample_req;
    logic               out_valid;
    logic               out_ready;
    logic [ENTRY_W-1:0] out_data;
    logic               overflow;
    logic [7:0]         drop_cnt;
    logic [LVL_W-1:0]   level;

    count_event_packetizer #(
        .CNT_W (CNT_W),
        .DEPTH (DEPTH),
        .SEQ_W (SEQ_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .count_in   (count_in),
        .count_en   (count_en),
        .sample_req (sample_req),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .level      (level)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [ENTRY_W-1:0] sb_q [$];
    int                 m_level;
    logic [SEQ_W-1:0]   m_seq;
    logic               m_ovf;
    int                 m_drop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        sample_req = 1'b0;
        count_en   = 1'b0;
        count_in   = '0;
        sb_q.delete();
        m_level = 0;
        m_seq   = '0;
        m_ovf   = 1'b0;
        m_drop  = 0;
        cyc();
        reset_n = 1'b1;
    endtask

    // Apply one cycle of stimulus and predict its effect.
    task automatic drive(input logic samp, input logic en, input logic [7:0] cnt, input logic rdy);
        logic       wrap;
        logic       evt;
        logic       pop;
        logic [1:0] ty;
        sample_req = samp;
        count_en   = en;
        count_in   = cnt;
        out_ready  = rdy;
        wrap = en && (cnt == 8'hFF);
        evt  = samp || wrap;
        ty   = {wrap, samp};
        pop  = (m_level != 0) && rdy;
        if (evt && (m_level < DEPTH || pop)) begin
            sb_q.push_back({ty, m_seq, cnt});
            m_seq = m_seq + 1'b1;
            if (!pop) m_level++;
        end else if (evt) begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop++;
        end else if (pop) begin
            m_level--;
        end
        cyc();
        sample_req = 1'b0;
        count_en   = 1'b0;
        check("level", 32'(level), 32'(m_level));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %0h expected no transfer at %0t", out_data, $time);
            end else begin
                check("sb_data", 32'(out_data), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ENTRY_W-1:0] d;
        out_ready = 1'b1;
        do_reset();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);

        // Single sample: visible one edge later, gone the next.
        drive(1'b1, 1'b0, 8'h12, 1'b1);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data", 32'(out_data), 32'h1012);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        check("t1_valid_off", 32'(out_valid), 32'd0);
        check("t1_level", 32'(level), 32'd0);

        // Sample and wrap together make one BOTH entry.
        drive(1'b1, 1'b1, 8'hFF, 1'b0);
        check("t2_data", 32'(out_data), {18'd0, EVT_BOTH, 4'h1, 8'hFF});
        check("t2_level", 32'(level), 32'd1);
        drain(1);
        // Enabled but not at all-ones: no event. At all-ones: wrap only.
        drive(1'b0, 1'b1, 8'hFE, 1'b0);
        check("t2_noevt_valid", 32'(out_valid), 32'd0);
        drive(1'b0, 1'b1, 8'hFF, 1'b0);
        check("t2_wrap_data", 32'(out_data), 32'h22FF);
        drain(1);

        // Overfill by one, drain in order, next accepted carries seq 4.
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
        check("t3_level", 32'(level), 32'd4);
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_drop", 32'(drop_cnt), 32'd1);
        check("t3_head", 32'(out_data), 32'h1020);
        drain(4);
        drive(1'b1, 1'b0, 8'h55, 1'b0);
        check("t3_seq4", 32'(out_data), 32'h1455);
        drain(1);

        // Full plus pop plus event: accepted, no drop.
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
        drive(1'b1, 1'b0, 8'h66, 1'b1);
        check("t4_level", 32'(level), 32'd4);
        check("t4_overflow", 32'(overflow), 32'd0);
        check("t4_drop", 32'(drop_cnt), 32'd0);
        check("t4_head", 32'(out_data), 32'h1131);
        drain(4);

        // Drop counter saturation.
        do_reset();
        for (int i = 0; i < 304; i++) drive(1'b1, 1'b0, 8'(i), 1'b0);
        check("t5_drop_sat", 32'(drop_cnt), 32'd255);
        drain(4);

        // Sequence wrap over 18 accepted events.
        do_reset();
        for (int i = 0; i < 18; i++) drive(1'b1, 1'b0, 8'(8'h80 + i), 1'b1);
        d = out_data;
        check("t5_seq_wrap", 32'(d[11:8]), 32'd1);
        check("t5_last_cnt", 32'(d[7:0]), 32'h91);
        drain(1);

        // Reset with entries in flight.
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        check("t6_pre_level", 32'(level), 32'd3);
        check("t6_pre_valid", 32'(out_valid), 32'd1);
        do_reset();
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_level", 32'(level), 32'd0);
        check("t6_drop", 32'(drop_cnt), 32'd0);
        check("t6_data", 32'(out_data), 32'd0);
        drive(1'b1, 1'b0, 8'h77, 1'b0);
        check("t6_seq0", 32'(out_data), 32'h1077);
        drain(2);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
